ic74ls163: RTL and testbench

- Simulation model of the 74LS163 synchronous 4-bit binary counter, in the same pin-numbered style as the other sim_ttl gate models.
- It is the clocked counterpart to our combinational gate chips. Control logic built from those gates (OR-combined enables, load strobes) drives this chip's LOAD/ENP/ENT/CLR pins.
- Used for the microcode step counter and the program counter slices; cascades through RCO into ENT of the next chip.

---
 rtl/ttl_pkg.sv | 32 +++
 rtl/ttl_sync_cnt4.sv | 89 ++++++++
 rtl/ic74ls163.sv | 53 +++++
 tb/tb_ic74ls163.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared types and constants for the sim_ttl counter models.
// Defining TTL_XCHECK_EN adds the pin numbers used by X/Z check messages.
package ttl_pkg;

   typedef logic [3:0] nibble_t;

   localparam nibble_t NIBBLE_MAX  = 4'hF;
   localparam int      TPD_DEFAULT = 0;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_COUNT,
      OP_LOAD,
      OP_CLEAR
   } cnt_op_e;

`ifdef TTL_XCHECK_EN
   typedef logic [4:0] pin_t;

   localparam pin_t PIN_NONE   = 5'd0;
   localparam pin_t PIN_CLR_N  = 5'd1;
   localparam pin_t PIN_A      = 5'd3;
   localparam pin_t PIN_ENP    = 5'd7;
   localparam pin_t PIN_LOAD_N = 5'd9;
   localparam pin_t PIN_ENT    = 5'd10;
`endif

   function automatic nibble_t nibble_inc(input nibble_t v);
      return v + 4'd1;
   endfunction

endpackage

// File: rtl/ttl_sync_cnt4.sv
// 4-bit synchronous counter core: clear > load > count > hold, RCO gated by ENT.
// Defining TTL_XCHECK_EN reports X/Z on the selecting controls and forces Q to X.
module ttl_sync_cnt4
   import ttl_pkg::*;
(
   input  logic    clk_i,
   input  logic    clr_n_i,
   input  logic    load_n_i,
   input  logic    enp_i,
   input  logic    ent_i,
   input  nibble_t d_i,
   output nibble_t q_o,
   output logic    rco_o
);

   cnt_op_e op;
   nibble_t q_q;
   nibble_t q_d;

   always_comb begin
      op = OP_HOLD;
      if (!clr_n_i) begin
         op = OP_CLEAR;
      end else if (!load_n_i) begin
         op = OP_LOAD;
      end else if (enp_i && ent_i) begin
         op = OP_COUNT;
      end
   end

   always_comb begin
      q_d = q_q;
      case (op)
         OP_CLEAR: q_d = '0;
         OP_LOAD:  q_d = d_i;
         OP_COUNT: q_d = nibble_inc(q_q);
         default:  q_d = q_q;
      endcase
   end

`ifdef TTL_XCHECK_EN
   pin_t x_pin;

   // Only the pins that actually select this edge's operation are checked.
   always_comb begin
      x_pin = PIN_NONE;
      if ($isunknown(clr_n_i)) begin
         x_pin = PIN_CLR_N;
      end else if (clr_n_i) begin
         if ($isunknown(load_n_i)) begin
            x_pin = PIN_LOAD_N;
         end else if (!load_n_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if ((x_pin == PIN_NONE) && $isunknown(d_i[i])) begin
                  x_pin = PIN_A + pin_t'(i);
               end
            end
         end else if ($isunknown(enp_i)) begin
            x_pin = PIN_ENP;
         end else if ($isunknown(ent_i)) begin
            x_pin = PIN_ENT;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (x_pin != PIN_NONE) begin
         $error("%m: X/Z on pin %0d", x_pin);
         q_q <= 'x;
      end else if (!clr_n_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end
`else
   always_ff @(posedge clk_i) begin
      if (!clr_n_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end
`endif

   assign q_o   = q_q;
   assign rco_o = ent_i & (q_q == NIBBLE_MAX);

endmodule

// File: rtl/ic74ls163.sv
// 74LS163 synchronous 4-bit binary counter, pin-numbered; pin mapping onto ttl_sync_cnt4.
// Defining TTL_XCHECK_EN enables X/Z checking of the control and data pins.
module ic74ls163
   import ttl_pkg::*;
#(
   parameter int TPD = TPD_DEFAULT
) (
   input  logic port1,
   input  logic port2,
   input  logic port3,
   input  logic port4,
   input  logic port5,
   input  logic port6,
   input  logic port7,
   input  logic port8,
   input  logic port9,
   input  logic port10,
   output logic port11,
   output logic port12,
   output logic port13,
   output logic port14,
   output logic port15,
   input  logic port16
);

   nibble_t q;
   logic    rco;
   logic    unused_supply;

   // TPD is accepted for override compatibility; outputs are modelled zero-delay.
   if (TPD < 0) begin : g_tpd_negative
   end

   assign unused_supply = port8 ^ port16;

   ttl_sync_cnt4 u_core (
      .clk_i    (port2),
      .clr_n_i  (port1),
      .load_n_i (port9),
      .enp_i    (port7),
      .ent_i    (port10),
      .d_i      ({port6, port5, port4, port3}),
      .q_o      (q),
      .rco_o    (rco)
   );

   assign port11 = q[3];
   assign port12 = q[2];
   assign port13 = q[1];
   assign port14 = q[0];
   assign port15 = rco;

endmodule

// File: tb/tb_ic74ls163.sv
// Self-checking bench for ic74ls163: directed scenarios, random stimulus and a two-chip cascade.
module tb_ic74ls163;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic gnd = 1'b0;
   logic vcc = 1'b1;

   logic       clr_n, load_n, enp, ent;
   logic [3:0] d;
   logic       qa, qb, qc, qd, rco;
   logic [3:0] q_obs;
   assign q_obs = {qd, qc, qb, qa};

   ic74ls163 #(.TPD(0)) u_dut (
      .port1 (clr_n), .port2 (clk),   .port3 (d[0]),  .port4 (d[1]),
      .port5 (d[2]),  .port6 (d[3]),  .port7 (enp),   .port8 (gnd),
      .port9 (load_n), .port10 (ent), .port11 (qd),   .port12 (qc),
      .port13 (qb),   .port14 (qa),   .port15 (rco),  .port16 (vcc)
   );

   // cascade pair: low chip always enabled, its RCO enables the high chip
   logic       c_clr_n, c_en;
   logic [3:0] lo_q, hi_q;
   logic       lo_rco, hi_rco;
   logic [3:0] c_d = 4'h0;
   logic       c_load_n = 1'b1;

   ic74ls163 #(.TPD(0)) u_lo (
      .port1 (c_clr_n), .port2 (clk),    .port3 (c_d[0]),  .port4 (c_d[1]),
      .port5 (c_d[2]),  .port6 (c_d[3]), .port7 (c_en),    .port8 (gnd),
      .port9 (c_load_n), .port10 (c_en), .port11 (lo_q[3]), .port12 (lo_q[2]),
      .port13 (lo_q[1]), .port14 (lo_q[0]), .port15 (lo_rco), .port16 (vcc)
   );

   ic74ls163 #(.TPD(0)) u_hi (
      .port1 (c_clr_n), .port2 (clk),    .port3 (c_d[0]),  .port4 (c_d[1]),
      .port5 (c_d[2]),  .port6 (c_d[3]), .port7 (lo_rco),  .port8 (gnd),
      .port9 (c_load_n), .port10 (lo_rco), .port11 (hi_q[3]), .port12 (hi_q[2]),
      .port13 (hi_q[1]), .port14 (hi_q[0]), .port15 (hi_rco), .port16 (vcc)
   );

   int checks = 0;
   int errors = 0;
   int mq     = 0;

   function automatic int model_next(int q, bit c, bit l, int dv, bit p, bit t);
      if (!c) return 0;
      if (!l) return dv;
      if (p && t) return (q + 1) % 16;
      return q;
   endfunction

   function automatic bit model_rco(int q, bit t);
      return t && (q == 15);
   endfunction

   task automatic step();
      @(posedge clk);
      mq = model_next(mq, clr_n, load_n, int'(d), enp, ent);
      #1;
   endtask

   task automatic test_reset();
      clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 4'h0;
      step();
      checks++;
      if (q_obs !== 4'h0 || rco !== 1'b0) begin
         errors++; $display("FAIL reset_first q=%h rco=%b want q=0 rco=0", q_obs, rco);
      end
      clr_n = 1'b1; load_n = 1'b0; d = 4'h9;
      step();
      checks++;
      if (q_obs !== 4'h9) begin
         errors++; $display("FAIL reset_preload q=%h want 9", q_obs);
      end
      clr_n = 1'b0; load_n = 1'b0; d = 4'hF; enp = 1'b1; ent = 1'b1;
      step();
      checks++;
      if (q_obs !== 4'h0 || rco !== 1'b0) begin
         errors++; $display("FAIL reset_beats_load q=%h rco=%b want q=0 rco=0", q_obs, rco);
      end
      clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0;
   endtask

   task automatic test_load();
      clr_n = 1'b1; load_n = 1'b0; d = 4'b1011; enp = 1'b1; ent = 1'b0;
      #2 enp = 1'b0; ent = 1'b1;
      #2 enp = 1'b1;
      step();
      checks++;
      if (q_obs !== 4'd11 || int'(q_obs) != mq) begin
         errors++; $display("FAIL load_1011 q=%0d want 11", q_obs);
      end
      for (int i = 0; i < 8; i++) begin
         d = 4'($urandom_range(0, 15)); enp = 1'($urandom); ent = 1'($urandom);
         step();
         checks++;
         if (int'(q_obs) != mq || rco !== model_rco(mq, ent)) begin
            errors++; $display("FAIL load_rand q=%h rco=%b want q=%h rco=%b", q_obs, rco, mq, model_rco(mq, ent));
         end
      end
      load_n = 1'b1;
   endtask

   task automatic test_count_wrap();
      int exp_seq[4] = '{14, 15, 0, 1};
      clr_n = 1'b1; load_n = 1'b0; d = 4'd13; enp = 1'b0; ent = 1'b0;
      step();
      load_n = 1'b1; enp = 1'b1; ent = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (int'(q_obs) != exp_seq[i] || int'(q_obs) != mq || rco !== (exp_seq[i] == 15)) begin
            errors++; $display("FAIL count_wrap step%0d q=%0d rco=%b want q=%0d rco=%b", i, q_obs, rco, exp_seq[i], exp_seq[i] == 15);
         end
      end
   endtask

   task automatic test_enables();
      clr_n = 1'b1; load_n = 1'b0; d = 4'hF; enp = 1'b0; ent = 1'b1;
      step();
      checks++;
      if (q_obs !== 4'hF || rco !== 1'b1) begin
         errors++; $display("FAIL load_f_rco q=%h rco=%b want q=f rco=1", q_obs, rco);
      end
      load_n = 1'b1; enp = 1'b0; ent = 1'b1;
      step();
      checks++;
      if (q_obs !== 4'hF || rco !== 1'b1) begin
         errors++; $display("FAIL enp_low_hold q=%h rco=%b want q=f rco=1", q_obs, rco);
      end
      ent = 1'b0;
      #1;
      checks++;
      if (rco !== 1'b0 || q_obs !== 4'hF) begin
         errors++; $display("FAIL ent_low_rco q=%h rco=%b want q=f rco=0", q_obs, rco);
      end
      enp = 1'b1;
      step();
      checks++;
      if (q_obs !== 4'hF || rco !== 1'b0) begin
         errors++; $display("FAIL ent_low_hold q=%h rco=%b want q=f rco=0", q_obs, rco);
      end
   endtask

   task automatic test_mid_reset();
      clr_n = 1'b1; load_n = 1'b0; d = 4'd5; enp = 1'b1; ent = 1'b1;
      step();
      load_n = 1'b1;
      step();
      checks++;
      if (q_obs !== 4'd6) begin
         errors++; $display("FAIL mid_count q=%0d want 6", q_obs);
      end
      clr_n = 1'b0;
      #2;
      checks++;
      if (q_obs !== 4'd6) begin
         errors++; $display("FAIL clr_between_edges q=%0d want 6", q_obs);
      end
      step();
      checks++;
      if (q_obs !== 4'd0 || mq != 0) begin
         errors++; $display("FAIL clr_at_edge q=%0d want 0", q_obs);
      end
      clr_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         clr_n  = ($urandom_range(0, 15) != 0);
         load_n = ($urandom_range(0, 5) != 0);
         enp    = ($urandom_range(0, 3) != 0);
         ent    = ($urandom_range(0, 3) != 0);
         d      = 4'($urandom_range(0, 15));
         step();
         checks++;
         if (int'(q_obs) != mq || rco !== model_rco(mq, ent)) begin
            errors++; $display("FAIL random%0d q=%h rco=%b want q=%h rco=%b", i, q_obs, rco, mq, model_rco(mq, ent));
         end
      end
   endtask

   task automatic test_cascade();
      int cnt;
      c_clr_n = 1'b0; c_en = 1'b1;
      @(posedge clk); #1;
      cnt = 0;
      c_clr_n = 1'b1;
      checks++;
      if ({hi_q, lo_q} !== 8'h00 || hi_rco !== 1'b0) begin
         errors++; $display("FAIL cascade_clear q=%h want 00", {hi_q, lo_q});
      end
      for (int i = 0; i < 255; i++) begin
         @(posedge clk); #1;
         cnt = (cnt + 1) % 256;
         checks++;
         if (int'({hi_q, lo_q}) != cnt || lo_rco !== (cnt % 16 == 15)) begin
            errors++; $display("FAIL cascade_edge%0d q=%h lo_rco=%b want q=%h", i, {hi_q, lo_q}, lo_rco, cnt);
         end
      end
      checks++;
      if ({hi_q, lo_q} !== 8'hFF || lo_rco !== 1'b1 || hi_rco !== 1'b1) begin
         errors++; $display("FAIL cascade_ff q=%h rco=%b%b want ff rco=11", {hi_q, lo_q}, hi_rco, lo_rco);
      end
      @(posedge clk); #1;
      checks++;
      if ({hi_q, lo_q} !== 8'h00 || hi_rco !== 1'b0) begin
         errors++; $display("FAIL cascade_wrap q=%h hi_rco=%b want 00 hi_rco=0", {hi_q, lo_q}, hi_rco);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 4'h0;
      c_clr_n = 1'b0; c_en = 1'b0;
      @(negedge clk);
      test_reset();
      test_load();
      test_count_wrap();
      test_enables();
      test_mid_reset();
      test_random();
      test_cascade();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
